// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access sizes, FSM states,
// default data memory size and the word-alignment helper.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mau_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } mau_state_e;

    localparam int MAU_MEM_BYTES = 512;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Big-endian lane logic: extracts and extends load data from a memory word,
// and merges right-justified store data into the addressed lanes.
module mau_lane_align
    import mau_pkg::*;
(
    input  mau_size_e   size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] ldata,
    output logic [31:0] mword
);

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic u);
        return u ? {24'd0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic u);
        return u ? {16'd0, h} : {{16{h[15]}}, h};
    endfunction

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte = rword[7:0];
        case (off)
            2'd0:    rbyte = rword[31:24];
            2'd1:    rbyte = rword[23:16];
            2'd2:    rbyte = rword[15:8];
            default: rbyte = rword[7:0];
        endcase
        rhalf = off[1] ? rword[15:0] : rword[31:16];
    end

    always_comb begin
        ldata = rword;
        mword = wdata;
        case (size)
            SZ_BYTE: begin
                ldata = ext8(rbyte, uns);
                case (off)
                    2'd0:    mword = {wdata[7:0], rword[23:0]};
                    2'd1:    mword = {rword[31:24], wdata[7:0], rword[15:0]};
                    2'd2:    mword = {rword[31:16], wdata[7:0], rword[7:0]};
                    default: mword = {rword[31:8], wdata[7:0]};
                endcase
            end
            SZ_HALF: begin
                ldata = ext16(rhalf, uns);
                mword = off[1] ? {rword[31:16], wdata[15:0]}
                               : {wdata[15:0], rword[15:0]};
            end
            default: begin
                ldata = rword;
                mword = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit driving a word-wide big-endian data memory.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_BYTES = MAU_MEM_BYTES
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        RW,
    output logic [31:0] DAddr,
    output logic [31:0] DataIn,
    input  logic [31:0] DataOut
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    mau_state_e  state;
    mau_size_e   size_q;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic [31:0] addr_al;
    logic        misalign;
    logic        reject;
    logic [31:0] ldata;
    logic [31:0] mword;

`ifdef MAU_MISALIGN_TRAP_EN
    always_comb begin
        addr_al  = addr;
        misalign = ((size == SZ_HALF) && addr[0]) ||
                   ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    end
`else
    // Drop the low address bits so halfwords and words are naturally aligned.
    always_comb begin
        addr_al  = addr;
        misalign = 1'b0;
        if (size == SZ_HALF) addr_al[0]   = 1'b0;
        if (size == SZ_WORD) addr_al[1:0] = 2'b00;
    end
`endif

    assign reject = (size == SZ_RSVD) || misalign || (word_addr(addr) >= MEM_LIMIT);

    mau_lane_align u_lane (
        .size  (size_q),
        .off   (off_q),
        .uns   (uns_q),
        .wdata (wdata_q),
        .rword (DataOut),
        .ldata (ldata),
        .mword (mword)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
            rdata  <= 32'd0;
            RW     <= 1'b0;
            DAddr  <= 32'd0;
            DataIn <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= 32'd0;
                    RW    <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        size_q  <= mau_size_e'(size);
                        uns_q   <= uns;
                        off_q   <= addr_al[1:0];
                        wdata_q <= wdata;
                        ready   <= 1'b0;
                        if (reject) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            DAddr <= word_addr(addr_al);
                            // Full-word stores need no read-modify-write.
                            if (we && (size == SZ_WORD)) begin
                                state  <= ST_WRITE;
                                RW     <= 1'b1;
                                DataIn <= wdata;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        state  <= ST_WRITE;
                        RW     <= 1'b1;
                        DataIn <= mword;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        rdata <= ldata;
                    end
                end
                ST_WRITE: begin
                    state <= ST_DONE;
                    RW    <= 1'b0;
                    done  <= 1'b1;
                    rdata <= 32'd0;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a word-wide memory model.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        RW;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;

    logic [31:0] mem [0:127];
    int          rw_cnt = 0;
    int          nchk = 0;
    int          nerr = 0;

    always #5 CLK = ~CLK;

    mem_access_unit #(.MEM_BYTES(512)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .req     (req),
        .we      (we),
        .size    (size),
        .uns     (uns),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .done    (done),
        .rdata   (rdata),
        .err     (err),
        .RW      (RW),
        .DAddr   (DAddr),
        .DataIn  (DataIn),
        .DataOut (DataOut)
    );

    assign DataOut = mem[DAddr[8:2]];

    always @(posedge CLK) begin
        if (RW) begin
            mem[DAddr[8:2]] <= DataIn;
            rw_cnt = rw_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and waits (bounded) for done; lat=0 means it never came.
    task automatic access(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        @(negedge CLK);
        we = w; size = s; uns = u; addr = a; wdata = d; req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0;
        lat = 0; rd = 32'hxxxxxxxx; e = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            if (done) begin
                lat = i; rd = rdata; e = err;
                break;
            end
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        e;
    int          rw0;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        mem[4]  = 32'h11A23344;
        mem[5]  = 32'h8001FF7F;
        mem[8]  = 32'hAABBCCDD;
        mem[9]  = 32'h11223344;
        mem[12] = 32'h55667788;
        mem[127] = 32'hCAFEF00D;
        Reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready",  {31'd0, ready}, 32'd1);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_err",    {31'd0, err},   32'd0);
        check("rst_rdata",  rdata,          32'd0);
        check("rst_rw",     {31'd0, RW},    32'd0);
        check("rst_daddr",  DAddr,          32'd0);
        check("rst_datain", DataIn,         32'd0);
        @(negedge CLK);
        Reset = 1'b0;

        access(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, lat, rd, e);
        check("ldb_s_lat",   lat, 2);
        check("ldb_s_data",  rd,  32'hFFFFFFA2);
        check("ldb_s_err",   {31'd0, e}, 32'd0);
        check("idle_ready",  {31'd0, ready}, 32'd1);

        access(1'b0, 2'b00, 1'b1, 32'h11, 32'd0, lat, rd, e);
        check("ldb_u_data",  rd, 32'h000000A2);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, lat, rd, e);
        check("ldb_off3",    rd, 32'h00000044);
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'd0, lat, rd, e);
        check("ldb_off0",    rd, 32'h00000011);
        access(1'b0, 2'b01, 1'b0, 32'h14, 32'd0, lat, rd, e);
        check("ldh_s_neg",   rd, 32'hFFFF8001);
        access(1'b0, 2'b01, 1'b1, 32'h16, 32'd0, lat, rd, e);
        check("ldh_u_off2",  rd, 32'h0000FF7F);
        access(1'b0, 2'b00, 1'b1, 32'h16, 32'd0, lat, rd, e);
        check("ldb_u_ff",    rd, 32'h000000FF);

        rw0 = rw_cnt;
        access(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, lat, rd, e);
        check("sth_lat",     lat, 3);
        check("sth_rdata",   rd, 32'd0);
        check("sth_writes",  rw_cnt - rw0, 1);
        check("sth_mem",     mem[8], 32'hAABB1234);

        access(1'b1, 2'b00, 1'b0, 32'h24, 32'h000000AB, lat, rd, e);
        check("stb_off0",    mem[9], 32'hAB223344);

        @(negedge CLK);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'hDEADBEEF; req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0;
        check("stw_rw_c1",   {31'd0, RW}, 32'd1);
        check("stw_daddr",   DAddr, 32'h40);
        check("stw_datain",  DataIn, 32'hDEADBEEF);
        @(posedge CLK);
        #1;
        check("stw_done_c2", {31'd0, done}, 32'd1);
        check("stw_rw_c2",   {31'd0, RW}, 32'd0);
        @(posedge CLK);
        #1;
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, lat, rd, e);
        check("ldw_back",    rd, 32'hDEADBEEF);
        check("ldw_lat",     lat, 2);

        rw0 = rw_cnt;
        access(1'b0, 2'b10, 1'b0, 32'h42, 32'd0, lat, rd, e);
`ifdef MAU_MISALIGN_TRAP_EN
        check("mis_lat",     lat, 1);
        check("mis_err",     {31'd0, e}, 32'd1);
        check("mis_rdata",   rd, 32'd0);
`else
        check("mis_lat",     lat, 2);
        check("mis_err",     {31'd0, e}, 32'd0);
        check("mis_rdata",   rd, 32'hDEADBEEF);
`endif
        check("mis_nowrite", rw_cnt - rw0, 0);

        rw0 = rw_cnt;
        access(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, lat, rd, e);
        check("oor_lat",     lat, 1);
        check("oor_err",     {31'd0, e}, 32'd1);
        check("oor_nowrite", rw_cnt - rw0, 0);
        access(1'b0, 2'b10, 1'b0, 32'h1FC, 32'd0, lat, rd, e);
        check("last_word",   rd, 32'hCAFEF00D);
        check("last_err",    {31'd0, e}, 32'd0);
        access(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, lat, rd, e);
        check("rsvd_err",    {31'd0, e}, 32'd1);
        check("rsvd_lat",    lat, 1);

        rw0 = rw_cnt;
        @(negedge CLK);
        we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h31; wdata = 32'h000000EE; req = 1'b1;
        @(posedge CLK);
        #1 req = 1'b0; Reset = 1'b1;
        check("rstrd_busy",  {31'd0, ready}, 32'd0);
        @(posedge CLK);
        #1 Reset = 1'b0;
        check("rstrd_ready", {31'd0, ready}, 32'd1);
        check("rstrd_rw",    {31'd0, RW}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("rstrd_nowr",  rw_cnt - rw0, 0);
        check("rstrd_mem",   mem[12], 32'h55667788);

        rw0 = rw_cnt;
        @(negedge CLK);
        we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h11; wdata = 32'd0; req = 1'b1;
        @(posedge CLK);
        #1 we = 1'b1; size = 2'b10; addr = 32'h44; wdata = 32'h12345678;
        @(posedge CLK);
        #1 req = 1'b0;
        check("busy_done",   {31'd0, done}, 32'd1);
        check("busy_rdata",  rdata, 32'hFFFFFFA2);
        repeat (3) @(posedge CLK);
        #1;
        check("busy_nowr",   rw_cnt - rw0, 0);
        check("busy_mem",    mem[17], 32'd0);
        check("busy_ready",  {31'd0, ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 512, meaning data memory size in bytes, used for range checking.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  1  CPU access request; sampled only when ready=1.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have port uns  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-008 SHALL have port addr  input  32  CPU byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-justified.
REQ-010 SHALL have port ready  output  1  idle and able to accept req.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  32  load result, valid while done=1.
REQ-013 SHALL have port err  output  1  access rejected, valid while done=1.
REQ-014 SHALL have port RW  output  1  memory write enable (1 = write).
REQ-015 SHALL have port DAddr  output  32  word-aligned memory address.
REQ-016 SHALL have port DataIn  output  32  memory write word.
REQ-017 SHALL have port DataOut  input  32  memory read word, big-endian: byte at DAddr is bits 31:24.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE; ready=1 only in IDLE.
REQ-019 SHALL latch we, size, uns, addr and wdata in the cycle where req=1 and ready=1, then leave IDLE.
- Transition targets: READ for loads and for sub-word stores; WRITE for word stores; DONE with err=1 for rejected accesses.
REQ-020 SHALL drive DAddr = {addr[31:2],2'b00} from READ through WRITE, and hold DAddr stable otherwise.
REQ-021 SHALL assert RW=1 only during the single WRITE cycle; RW=0 in every other state.
REQ-022 SHALL capture DataOut at the end of READ.
- Load: go to DONE with the extracted, extended value.
- Sub-word store: go to WRITE with the merged word, replacing only the addressed byte or halfword lanes.
REQ-023 SHALL select lanes big-endian.
- Byte offset 0 maps to bits 31:24 and offset 3 to bits 7:0.
- Halfword offset 0 maps to bits 31:16 and offset 2 to bits 15:0.
REQ-024 SHALL complete with the following latency, counted from the acceptance edge:
- Load: 2 cycles (done in the 2nd cycle after acceptance).
- Word store: 2 cycles.
- Sub-word store: 3 cycles.
- Rejected access: 1 cycle.
REQ-025 SHALL assert done for exactly one cycle in DONE, return to IDLE next cycle, and set rdata=0 for stores and errors.
REQ-026 SHALL reject (err=1, RW never asserted) any access with size=11 or with addr[31:2]*4 >= MEM_BYTES.
REQ-027 SHALL ignore req while ready=0; there is no queuing.

Reset
REQ-028 SHALL, when Reset=1 at a rising edge, force state IDLE, ready=1, done=0, err=0, rdata=0, RW=0, DAddr=0, DataIn=0, regardless of state.
REQ-029 SHALL abandon an in-flight access on reset; a sub-word store reset in READ never writes memory.

Configuration
REQ-030 SHALL honour macro MAU_MISALIGN_TRAP_EN.
- When defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 is rejected as in REQ-026.
- When undefined: low address bits are forced to zero to give natural alignment, and the access proceeds normally.

Structure
REQ-031 SHALL take the size encodings, the FSM state encoding and the MEM_BYTES default from shared package mau_pkg.
REQ-032 SHALL place lane extraction, extension and store merge in combinational sub-module mau_lane_align; the FSM stays in mem_access_unit.

Verification
REQ-033 Load byte, signed: memory word at 0x10 = 0x11A23344; load byte, uns=0, addr=0x11 -> done after 2 cycles, rdata=0xFFFFFFA2, err=0.
REQ-034 Store halfword: memory word at 0x20 = 0xAABBCCDD; store halfword, addr=0x22, wdata=0x00001234 -> one RW=1 cycle with DataIn=0xAABB1234, done after 3 cycles.
REQ-035 Store word: store word, addr=0x40, wdata=0xDEADBEEF -> RW=1 in cycle 1 with DAddr=0x40, no READ state, done in cycle 2; a following load word from 0x40 returns 0xDEADBEEF.
REQ-036 Misaligned word load at addr=0x42:
- With MAU_MISALIGN_TRAP_EN: done after 1 cycle, err=1, RW stays 0.
- Without it: reads word 0x40 and returns the same data as an aligned load.
REQ-037 Out of range and reserved size: addr=0x200 with MEM_BYTES=512 -> err=1 and no write; size=11 -> err=1.
REQ-038 Reset and busy behaviour: Reset=1 in READ of a byte store -> next cycle IDLE, ready=1, RW never 1, memory unchanged; a req pulsed while busy is ignored.
